// File: rtl/arb2_mux4_pkg.sv
// Shared definitions for the two-requester arbiter family: state
// encodings and the helper that resolves one arbitration decision.
package arb2_mux4_pkg;

  // Grant states; encodings are fixed so later arbiters can reuse them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  // Requester identifiers as carried on SEL and in the LAST register.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Picks the winner when both requesters are asking: whoever was not
  // served last, which gives strict alternation under a sustained tie.
  function automatic logic tie_winner(input logic last);
    return ~last;
  endfunction

endpackage

// File: rtl/arb2_mux4_mux4bit.sv
// Plain 2:1 multiplexer for a 4-bit word; S=0 passes A, S=1 passes B.
module mux4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       S,
  output logic [3:0] Y
);

  // Pure combinational word select.
  always_comb begin
    Y = S ? B : A;
  end

endmodule

// File: rtl/arb2_mux4.sv
// Two-requester fair arbiter feeding one registered 4-bit output word
// with a valid/ready handshake towards the consumer.
module arb2_mux4
  import arb2_mux4_pkg::*;
#(
  parameter logic STARTPRI = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQA,
  input  logic [3:0] DA,
  output logic       ACKA,
  input  logic       REQB,
  input  logic [3:0] DB,
  output logic       ACKB,
  output logic [3:0] O,
  output logic       OV,
  input  logic       ORDY,
  output logic       SEL
);

  arb_state_t state_q;
  arb_state_t state_nxt;
  logic       last_q;
  logic [3:0] o_q;
  logic       sel_q;
  logic       load;
  logic       grant;
  logic       arb_point;
  logic [3:0] mux_word;

  // A new decision may be taken whenever nothing is held, or the held
  // word leaves this cycle; otherwise everything stays frozen.
  assign arb_point = (state_q == IDLE) || ORDY;

  // The only path from the requesters' data into the output register.
  mux4bit u_mux (
    .A (DA),
    .B (DB),
    .S (grant),
    .Y (mux_word)
  );

  // Next-state and grant decision; grant doubles as the mux select.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    grant     = sel_q;
    if (arb_point) begin
      unique case ({REQA, REQB})
        2'b10: begin
          state_nxt = GNT_A;
          load      = 1'b1;
          grant     = OWNER_A;
        end
        2'b01: begin
          state_nxt = GNT_B;
          load      = 1'b1;
          grant     = OWNER_B;
        end
        2'b11: begin
          grant     = tie_winner(last_q);
          state_nxt = (grant == OWNER_B) ? GNT_B : GNT_A;
          load      = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, captured word, owner and fairness history; reset discards any
  // pending word and primes LAST so the first tie goes to STARTPRI.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      o_q     <= 4'b0000;
      sel_q   <= OWNER_A;
      last_q  <= ~STARTPRI;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        o_q    <= mux_word;
        sel_q  <= grant;
        last_q <= grant;
      end
    end
  end

  // Handshake outputs; acknowledges are combinational on ORDY so the
  // requester can present its next word at the same edge.
  always_comb begin
    OV   = (state_q == GNT_A) || (state_q == GNT_B);
    ACKA = (state_q == GNT_A) && ORDY;
    ACKB = (state_q == GNT_B) && ORDY;
    O    = o_q;
    SEL  = sel_q;
  end

endmodule
